// File: rtl/dual_port_memory.sv
// rtl/dual_port_memory.sv - dual-port RAM (A read-only, B read/write) with reset-time clear sequencer
// Define MEM_PARITY_EN to store a parity bit per word, checked on port B reads.
module dual_port_memory #(
  parameter int                DATA_W         = 8,
  parameter int                ADDR_W         = 8,
  parameter int                DEPTH          = 2**ADDR_W,
  parameter int                RD_LAT         = 1,
  parameter bit                CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_W-1:0] CLEAR_VALUE    = {DATA_W{1'b1}}
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  output logic              o_ready,
  input  logic              i_a_en,
  input  logic [ADDR_W-1:0] i_a_addr,
  output logic [DATA_W-1:0] o_a_data,
  output logic              o_a_valid,
  input  logic              i_b_en,
  input  logic              i_b_we,
  input  logic [ADDR_W-1:0] i_b_addr,
  input  logic [DATA_W-1:0] i_b_wdata,
  input  logic              i_b_perr_inj,
  output logic [DATA_W-1:0] o_b_rdata,
  output logic              o_b_valid,
  output logic              o_b_perr
);

`ifdef MEM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif
  localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic {S_CLEAR, S_RUN} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              ready_q;
  logic [DATA_W-1:0] a_data_q;
  logic              a_valid_q;
  logic [DATA_W-1:0] b_data_q;
  logic              b_valid_q;
  logic              b_perr_q;

  logic [MEM_W-1:0]  mem_q [DEPTH];

  logic              a_in_range;
  logic              b_in_range;
  logic              a_rd;
  logic              b_rd;
  logic              b_wr;
  logic [MEM_W-1:0]  a_word;
  logic [MEM_W-1:0]  b_word;
  logic              b_perr_now;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [MEM_W-1:0]  wr_word;

  assign a_in_range = {1'b0, i_a_addr} < DEPTH_L;
  assign b_in_range = {1'b0, i_b_addr} < DEPTH_L;

  // Requests are only honoured once the clear has finished (ready_q).
  assign a_rd = ready_q & i_a_en;
  assign b_rd = ready_q & i_b_en & ~i_b_we;
  assign b_wr = ready_q & i_b_en & i_b_we & b_in_range;

  assign a_word = a_in_range ? mem_q[i_a_addr] : '0;
  assign b_word = b_in_range ? mem_q[i_b_addr] : '0;

  assign wr_en   = (state_q == S_CLEAR) | b_wr;
  assign wr_addr = (state_q == S_CLEAR) ? cnt_q : i_b_addr;

`ifdef MEM_PARITY_EN
  assign wr_word    = (state_q == S_CLEAR) ? {^CLEAR_VALUE, CLEAR_VALUE}
                                           : {(^i_b_wdata) ^ i_b_perr_inj, i_b_wdata};
  assign b_perr_now = b_word[DATA_W] != (^b_word[DATA_W-1:0]);
`else
  logic unused_perr_inj;
  assign unused_perr_inj = i_b_perr_inj;
  assign wr_word    = (state_q == S_CLEAR) ? CLEAR_VALUE : i_b_wdata;
  assign b_perr_now = 1'b0;
`endif

  // Array has no reset so contents survive when CLEAR_ON_RESET=0.
  always_ff @(posedge i_clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_word;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q   <= CLEAR_ON_RESET ? S_CLEAR : S_RUN;
      cnt_q     <= '0;
      ready_q   <= 1'b0;
      a_data_q  <= '0;
      a_valid_q <= 1'b0;
      b_data_q  <= '0;
      b_valid_q <= 1'b0;
      b_perr_q  <= 1'b0;
    end else begin
      case (state_q)
        S_CLEAR: begin
          if (cnt_q == LAST_ADDR) begin
            state_q <= S_RUN;
            ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_RUN:   ready_q <= 1'b1;
        default: state_q <= S_RUN;
      endcase
      a_valid_q <= a_rd;
      if (a_rd) a_data_q <= a_word[DATA_W-1:0];
      b_valid_q <= b_rd;
      b_perr_q  <= b_rd & b_perr_now;
      if (b_rd) b_data_q <= b_word[DATA_W-1:0];
    end
  end

  assign o_ready   = ready_q;
  assign o_a_data  = (RD_LAT == 0) ? a_word[DATA_W-1:0] : a_data_q;
  assign o_a_valid = (RD_LAT == 0) ? a_rd : a_valid_q;
  assign o_b_rdata = (RD_LAT == 0) ? b_word[DATA_W-1:0] : b_data_q;
  assign o_b_valid = (RD_LAT == 0) ? b_rd : b_valid_q;
  assign o_b_perr  = (RD_LAT == 0) ? (b_rd & b_perr_now) : b_perr_q;

endmodule

// File: tb/tb_dual_port_memory.sv
// tb/tb_dual_port_memory.sv - randomized bench for dual_port_memory against an array reference model
// Honours MEM_PARITY_EN for the parity-injection checks.
module tb_dual_port_memory;

  localparam int L1 = 0;  // RD_LAT=1, DEPTH=256
  localparam int L0 = 1;  // RD_LAT=0, DEPTH=200
`ifdef MEM_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic       clk;
  logic       rstn;
  logic       a_en;
  logic [7:0] a_addr;
  logic       b_en;
  logic       b_we;
  logic [7:0] b_addr;
  logic [7:0] b_wdata;
  logic       b_inj;

  logic       rdy [2];
  logic [7:0] ad  [2];
  logic       av  [2];
  logic [7:0] bd  [2];
  logic       bv  [2];
  logic       bp  [2];

  int         dep [2] = '{256, 200};
  logic [7:0] mem_m  [2][256];
  logic       perr_m [2][256];
  logic       ready_m [2];
  int         clr_cnt [2];
  logic       exp_av, exp_bv, exp_bp;
  logic [7:0] exp_ad, exp_bd;
  int         n_checks = 0;
  int         n_errors = 0;
  int         n;

  dual_port_memory #(.RD_LAT(1)) u_lat1 (
    .i_clk(clk), .i_rstn(rstn), .o_ready(rdy[L1]),
    .i_a_en(a_en), .i_a_addr(a_addr), .o_a_data(ad[L1]), .o_a_valid(av[L1]),
    .i_b_en(b_en), .i_b_we(b_we), .i_b_addr(b_addr), .i_b_wdata(b_wdata),
    .i_b_perr_inj(b_inj), .o_b_rdata(bd[L1]), .o_b_valid(bv[L1]), .o_b_perr(bp[L1])
  );

  dual_port_memory #(.RD_LAT(0), .DEPTH(200)) u_lat0 (
    .i_clk(clk), .i_rstn(rstn), .o_ready(rdy[L0]),
    .i_a_en(a_en), .i_a_addr(a_addr), .o_a_data(ad[L0]), .o_a_valid(av[L0]),
    .i_b_en(b_en), .i_b_we(b_we), .i_b_addr(b_addr), .i_b_wdata(b_wdata),
    .i_b_perr_inj(b_inj), .o_b_rdata(bd[L0]), .o_b_valid(bv[L0]), .o_b_perr(bp[L0])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [7:0] mrd(input int i, input logic [7:0] a);
    return (int'(a) < dep[i]) ? mem_m[i][a] : 8'h00;
  endfunction

  function automatic logic mperr(input int i, input logic [7:0] a);
    return (int'(a) < dep[i]) ? perr_m[i][a] : 1'b0;
  endfunction

  function automatic logic [7:0] pick_addr();
    return ($urandom % 2 == 0) ? 8'($urandom_range(195, 204)) : 8'($urandom);
  endfunction

  task automatic idle();
    a_en = 0; a_addr = 0; b_en = 0; b_we = 0; b_addr = 0; b_wdata = 0; b_inj = 0;
  endtask

  task automatic rand_inputs();
    a_en    = 1'($urandom);
    a_addr  = pick_addr();
    b_en    = 1'($urandom);
    b_we    = 1'($urandom);
    b_addr  = pick_addr();
    b_wdata = 8'($urandom);
    b_inj   = ($urandom % 4 == 0);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      ready_m[i] = 1'b0;
      clr_cnt[i] = 0;
    end
    exp_av = 0; exp_ad = 0; exp_bv = 0; exp_bd = 0; exp_bp = 0;
  endtask

  // One clock: check outputs for current inputs at negedge, then commit the model at posedge.
  task automatic step();
    @(negedge clk);
    check("l0_rdy", rdy[L0], ready_m[L0]);
    check("l0_a_vld", av[L0], a_en & ready_m[L0]);
    if (a_en && ready_m[L0]) check("l0_a_data", ad[L0], mrd(L0, a_addr));
    check("l0_b_vld", bv[L0], b_en & !b_we & ready_m[L0]);
    if (b_en && !b_we && ready_m[L0]) begin
      check("l0_b_data", bd[L0], mrd(L0, b_addr));
      check("l0_b_perr", bp[L0], mperr(L0, b_addr));
    end else begin
      check("l0_b_perr_idle", bp[L0], 0);
    end
    check("l1_rdy", rdy[L1], ready_m[L1]);
    check("l1_a_vld", av[L1], exp_av);
    check("l1_a_data", ad[L1], exp_ad);
    check("l1_b_vld", bv[L1], exp_bv);
    check("l1_b_data", bd[L1], exp_bd);
    check("l1_b_perr", bp[L1], exp_bp);
    exp_av = a_en && ready_m[L1];
    if (exp_av) exp_ad = mrd(L1, a_addr);
    exp_bv = b_en && !b_we && ready_m[L1];
    exp_bp = exp_bv ? mperr(L1, b_addr) : 1'b0;
    if (exp_bv) exp_bd = mrd(L1, b_addr);
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (!ready_m[i]) begin
        clr_cnt[i]++;
        if (clr_cnt[i] == dep[i]) begin
          ready_m[i] = 1'b1;
          for (int k = 0; k < 256; k++) begin
            mem_m[i][k]  = 8'hFF;
            perr_m[i][k] = 1'b0;
          end
        end
      end else if (b_en && b_we && int'(b_addr) < dep[i]) begin
        mem_m[i][b_addr]  = b_wdata;
        perr_m[i][b_addr] = PAR ? b_inj : 1'b0;
      end
    end
    #1;
  endtask

  task automatic release_and_clear(input string tag);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    n = 0;
    while (!rdy[L1] && n < 400) begin
      rand_inputs();
      step();
      n++;
    end
    check(tag, n, 256);
    idle();
  endtask

  initial begin
    idle();
    rstn = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_rdy1", rdy[L1], 0);
    check("rst_rdy0", rdy[L0], 0);
    check("rst_a_vld1", av[L1], 0);
    check("rst_a_data1", ad[L1], 0);
    check("rst_b_vld1", bv[L1], 0);
    check("rst_b_data1", bd[L1], 0);
    check("rst_b_perr1", bp[L1], 0);
    check("rst_a_vld0", av[L0], 0);

    release_and_clear("clr_len");

    for (int a = 0; a < 256; a++) begin
      a_en = 1; a_addr = 8'(a);
      b_en = 1; b_we = 0; b_addr = 8'(255 - a);
      step();
    end
    idle();

    b_en = 1; b_we = 1; b_addr = 8'h10; b_wdata = 8'h5A;
    step();
    idle(); a_en = 1; a_addr = 8'h10;
    step();
    check("rd_after_wr", ad[L1], 8'h5A);
    check("rd_after_wr_vld", av[L1], 1);

    a_en = 1; a_addr = 8'h20; b_en = 1; b_we = 1; b_addr = 8'h20; b_wdata = 8'h33;
    step();
    check("coll_read_first", ad[L1], 8'hFF);
    idle(); a_en = 1; a_addr = 8'h20;
    step();
    check("coll_next_read", ad[L1], 8'h33);

    for (int a = 0; a < 4; a++) begin
      idle(); a_en = 1; a_addr = 8'(a);
      step();
    end

    idle(); b_en = 1; b_we = 1; b_addr = 8'd250; b_wdata = 8'hAA;
    step();
    idle(); a_en = 1; a_addr = 8'd250; b_en = 1; b_addr = 8'd250;
    step();

`ifdef MEM_PARITY_EN
    idle(); b_en = 1; b_we = 1; b_addr = 8'h05; b_wdata = 8'h0F; b_inj = 1;
    step();
    idle(); b_en = 1; b_addr = 8'h05;
    step();
    check("perr_inj", bp[L1], 1);
    idle(); b_en = 1; b_we = 1; b_addr = 8'h05; b_wdata = 8'h0F;
    step();
    idle(); b_en = 1; b_addr = 8'h05;
    step();
    check("perr_clean", bp[L1], 0);
`endif

    repeat (400) begin
      rand_inputs();
      step();
    end

    idle(); a_en = 1; a_addr = 8'h07;
    step();
    rstn = 1'b0;
    #1;
    check("run_rst_rdy", rdy[L1], 0);
    check("run_rst_a_vld", av[L1], 0);
    check("run_rst_a_data", ad[L1], 0);
    check("run_rst_b_data", bd[L1], 0);
    check("run_rst_a_vld0", av[L0], 0);
    model_reset();
    idle();

    @(posedge clk);
    #1;
    rstn = 1'b1;
    repeat (100) begin
      rand_inputs();
      step();
    end
    rstn = 1'b0;
    #1;
    check("clr_rst_rdy", rdy[L1], 0);
    check("clr_rst_a_vld", av[L1], 0);
    model_reset();
    idle();
    release_and_clear("clr_restart_len");

    repeat (150) begin
      rand_inputs();
      step();
    end
    idle();
    step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
